// File: rtl/press_code_sequencer_pkg.sv
// Shared types for the press-code sequencer: FSM state encoding, symbol values
// and a small elaboration-time helper.
package pcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_HOLD,
    ST_WAIT_REL
  } pcs_state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_code_sequencer_ms_tick_gen.sv
// Free-running millisecond prescaler: ms_tick is high for the one clk in which
// the counter sits at TICK_DIV-1, then the counter wraps to 0.
module ms_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(TICK_DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign ms_tick = (r_cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/press_code_sequencer.sv
// Times presses/releases of the clean button level, builds a dot/dash code word
// and offers it on a valid/ready port. Define PCS_INPUT_SYNC_EN for a 2-flop input sync.
//
// Handshake: code_valid rises when a group closes and holds code_bits/code_len/
// code_ovf unchanged until a clk with code_valid && code_ready; the word is
// consumed on that clk and code_valid drops on the following clk.
module press_code_sequencer
  import pcs_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int DASH_MS    = 140,
  parameter int GAP_MS     = 500,
  parameter int ABORT_MS   = 3000,
  parameter int MAX_SYMS   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_in,
  input  logic                         code_ready,
  output logic                         code_valid,
  output logic [MAX_SYMS-1:0]          code_bits,
  output logic [$clog2(MAX_SYMS+1)-1:0] code_len,
  output logic                         code_ovf,
  output logic                         busy,
  output pcs_state_t                   dbg_state
);

  localparam int LEN_W   = $clog2(MAX_SYMS + 1);
  localparam int DUR_MAX = max_int(ABORT_MS, GAP_MS);
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

  logic w_raw, w_lvl, w_press_edge, w_rel_edge, w_tick, w_sym;
  logic r_prev;
  logic [DUR_W-1:0] r_dur;
  pcs_state_t r_state;
  logic r_valid, r_ovf;
  logic [MAX_SYMS-1:0] r_bits;
  logic [LEN_W-1:0] r_len;

`ifdef PCS_INPUT_SYNC_EN
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  logic r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = r_sync2;
`else
  assign w_raw = btn_in;
`endif

  assign w_lvl        = (ACTIVE_LOW != 0) ? ~w_raw : w_raw;
  assign w_press_edge = w_lvl & ~r_prev;
  assign w_rel_edge   = ~w_lvl & r_prev;
  assign w_sym        = (r_dur >= DUR_W'(DASH_MS)) ? SYM_DASH : SYM_DOT;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (w_tick)
  );

  // Duration restarts on every level edge and saturates so long holds never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_dur  <= '0;
    end else begin
      r_prev <= w_lvl;
      if (w_press_edge || w_rel_edge) begin
        r_dur <= '0;
      end else if (w_tick && (r_dur != DUR_W'(DUR_MAX))) begin
        r_dur <= r_dur + DUR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_bits  <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press_edge) r_state <= ST_PRESS;
        end
        ST_PRESS: begin
          if (r_dur >= DUR_W'(ABORT_MS)) begin
            r_state <= ST_WAIT_REL;
            r_bits  <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
          end else if (w_rel_edge) begin
            r_state <= ST_GAP;
            if (r_len < LEN_W'(MAX_SYMS)) begin
              for (int i = 0; i < MAX_SYMS; i++) begin
                if (LEN_W'(i) == r_len) r_bits[i] <= w_sym;
              end
              r_len <= r_len + LEN_W'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          // A press on the same clk as the gap expiring keeps the group open.
          if (w_press_edge) begin
            r_state <= ST_PRESS;
          end else if (r_dur >= DUR_W'(GAP_MS)) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (code_ready) begin
            r_valid <= 1'b0;
            r_bits  <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
            r_state <= w_lvl ? ST_WAIT_REL : ST_IDLE;
          end
        end
        ST_WAIT_REL: begin
          if (!w_lvl) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign code_valid = r_valid;
  assign code_bits  = r_bits;
  assign code_len   = r_len;
  assign code_ovf   = r_ovf;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_press_code_sequencer.sv
// Bench for press_code_sequencer with scaled-down timing (4 clk per ms tick);
// expected code words come from a press-duration model and an expected queue.
module tb_press_code_sequencer;
  import pcs_pkg::*;

  localparam int T     = 4;
  localparam int DASH  = 14;
  localparam int GAP   = 50;
  localparam int ABORT = 300;
  localparam int NS    = 4;
  localparam int LW    = $clog2(NS + 1);
  localparam int W     = 1 + LW + NS;
`ifdef PCS_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b1;
  logic code_ready = 1'b0;
  logic code_valid, code_ovf, busy;
  logic [NS-1:0] code_bits;
  logic [LW-1:0] code_len;
  pcs_state_t dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  logic [W-1:0] exp_q[$];
  logic [NS-1:0] m_bits;
  int m_len;
  logic m_ovf;

  press_code_sequencer #(
    .TICK_DIV(T), .DASH_MS(DASH), .GAP_MS(GAP), .ABORT_MS(ABORT),
    .MAX_SYMS(NS), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .code_ready(code_ready),
    .code_valid(code_valid), .code_bits(code_bits), .code_len(code_len),
    .code_ovf(code_ovf), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock/reset block; cyc counts clks since reset so presses can start just after a ms boundary.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Reference model: each press of d ms is a dash if d >= DASH, aborts the group if d >= ABORT.
  task automatic model_clear();
    m_bits = '0;
    m_len  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_press(input int d);
    if (d >= ABORT) begin
      model_clear();
    end else if (m_len < NS) begin
      m_bits[m_len] = (d >= DASH);
      m_len++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic close_group();
    exp_q.push_back({m_ovf, LW'(m_len), m_bits});
    model_clear();
  endtask

  // Driver tasks (active-low button).
  task automatic align();
    while (cyc % T != 0) @(negedge clk);
  endtask

  task automatic do_press(input int d);
    align();
    btn_in = 1'b0;
    repeat (d * T) @(negedge clk);
    btn_in = 1'b1;
    model_press(d);
  endtask

  task automatic do_release(input int g);
    repeat (g * T) @(negedge clk);
  endtask

  task automatic expect_code(input string name);
    int waited;
    logic [W-1:0] got, exp;
    waited = 0;
    while (!code_valid && waited < 2 * GAP * T + 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!code_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: code_valid=0 after %0d cycles, required 1", name, waited);
      return;
    end
    got = {code_ovf, code_len, code_bits};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: got code %h, required no code", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_code: got ovf/len/bits=%h, required %h", name, got, exp);
      end
    end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    n_checks++;
    if (!code_valid || ({code_ovf, code_len, code_bits} !== got)) begin
      n_fail++;
      $display("FAIL %s_stable: got valid=%b code=%h, required valid=1 code=%h",
               name, code_valid, {code_ovf, code_len, code_bits}, got);
    end
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    n_checks++;
    if (code_valid !== 1'b0 || code_len !== '0 || code_bits !== '0 || code_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_consume: got valid=%b len=%0d bits=%b ovf=%b, required all 0",
               name, code_valid, code_len, code_bits, code_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (code_valid !== 1'b0 || code_bits !== '0 || code_len !== '0 ||
        code_ovf !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset: got valid=%b bits=%b len=%0d ovf=%b busy=%b, required all 0",
               code_valid, code_bits, code_len, code_ovf, busy);
    end
    model_clear();
  endtask

  task automatic test_basic();
    do_press(10); do_release(5);
    do_press(15); do_release(5);
    do_press(20); do_release(5);
    do_press(15);
    close_group();
    repeat (GAP * T + SYNC_LAT) @(negedge clk);
    n_checks++;
    if (code_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_early: got valid=%b busy=%b one clk before gap end, required 0/1",
               code_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (code_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid_time: got valid=%b at gap end, required 1", code_valid);
    end
    expect_code("basic");
  endtask

  task automatic test_overflow();
    do_press(10); do_release(5);
    do_press(15); do_release(5);
    do_press(20); do_release(5);
    do_press(15); do_release(5);
    do_press(10);
    close_group();
    do_release(GAP + 5);
    expect_code("overflow");
  endtask

  task automatic test_boundaries();
    do_press(DASH);
    close_group();
    do_release(GAP + 5);
    expect_code("dash_exact");
    do_press(DASH - 1);
    close_group();
    do_release(GAP + 5);
    expect_code("dot_below");
    do_press(5); do_release(GAP - 1);
    do_press(30);
    close_group();
    do_release(GAP + 5);
    expect_code("gap_below");
  endtask

  task automatic test_abort();
    int seen;
    align();
    btn_in = 1'b0;
    repeat (320 * T) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_held: got busy=%b valid=%b, required 1/0", busy, code_valid);
    end
    repeat (30 * T) @(negedge clk);
    btn_in = 1'b1;
    model_press(350);
    repeat (4 + SYNC_LAT) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: got busy=%b after release, required 0", busy);
    end
    seen = 0;
    repeat (100 * T) begin
      @(negedge clk);
      if (code_valid) seen = 1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_code: got code_valid seen=%0d, required 0", seen);
    end
    do_press(10);
    close_group();
    do_release(GAP + 5);
    expect_code("after_abort");
  endtask

  task automatic test_hold();
    int bad, waited;
    logic [W-1:0] snap;
    do_press(20);
    close_group();
    do_release(GAP + 5);
    waited = 0;
    while (!code_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    snap = {code_ovf, code_len, code_bits};
    bad = 0;
    repeat (200) begin
      btn_in = 1'($urandom_range(0, 1));
      repeat (T) @(negedge clk);
      if (!code_valid || ({code_ovf, code_len, code_bits} !== snap)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: got %0d unstable samples, required 0", bad);
    end
    btn_in = 1'b1;
    repeat (8) @(negedge clk);
    expect_code("hold");
    bad = 0;
    repeat ((GAP + 10) * T) begin
      @(negedge clk);
      if (code_valid || code_len != 0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_no_new_syms: got %0d samples with a code, required 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    do_press(10); do_release(5);
    align();
    btn_in = 1'b0;
    repeat (7 * T) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    btn_in = 1'b1;
    model_clear();
    n_checks++;
    if (code_valid !== 1'b0 || code_bits !== '0 || code_len !== '0 ||
        code_ovf !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b bits=%b len=%0d ovf=%b busy=%b, required all 0",
               code_valid, code_bits, code_len, code_ovf, busy);
    end
    do_release(5);
    do_press(20); do_release(5);
    do_press(15);
    close_group();
    do_release(GAP + 5);
    expect_code("mid_reset_group");
  endtask

  task automatic test_random();
    int np;
    for (int g = 0; g < 6; g++) begin
      np = $urandom_range(1, 6);
      for (int k = 0; k < np; k++) begin
        do_press($urandom_range(2, 40));
        if (k < np - 1) do_release($urandom_range(1, GAP - 2));
      end
      close_group();
      do_release(GAP + 3);
      expect_code("random");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_boundaries();
    test_abort();
    test_hold();
    test_mid_reset();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d unconsumed expected codes, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
